trap_ctrl: RTL and testbench

//  Parametrised trap/debug-entry sequencer between the execute stage and the CSR file. Accepts NUM_IRQ level interrupt lines

---
 rtl/trap_ctrl_if.sv | 24 ++
 rtl/trap_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// CSR-file side of the trap sequencer: current CSR values in, single CSR write port out.
interface trap_ctrl_if;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic [31:0] dpc_i;
  logic [31:0] dcsr_i;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;

  // Sequencer side
  modport master (
    input  mtvec_i, mepc_i, mstatus_i, mie_i, dpc_i, dcsr_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o
  );

  // CSR file side
  modport slave (
    output mtvec_i, mepc_i, mstatus_i, mie_i, dpc_i, dcsr_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap / debug-entry sequencer: arbitrates exceptions, debug entry, interrupts, mret and dret,
// then sequences the CSR writes and the fetch redirect. Optional feature macro: TRAP_VECTORED_EN.
module trap_ctrl #(
  parameter int unsigned NUM_IRQ    = 16,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inst_valid_i,
  input  logic               inst_executed_i,
  input  logic [31:0]        inst_addr_i,
  input  logic [31:0]        inst_i,
  input  logic               illegal_inst_i,
  input  logic               inst_ecall_i,
  input  logic               inst_ebreak_i,
  input  logic               inst_mret_i,
  input  logic               inst_dret_i,
  trap_ctrl_if.master        csr,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               debug_req_i,
  input  logic [31:0]        debug_halt_addr_i,
  output logic               stall_flag_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o,
  output logic [NUM_IRQ-1:0] irq_ack_o
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned DCAUSE_W  = 3;
  localparam int unsigned IRQ_BASE  = 16;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_DCSR    = 12'h7B0;
  localparam logic [11:0] CSR_DPC     = 12'h7B1;

  localparam logic [DCAUSE_W-1:0] DCAUSE_STEP   = 3'd4;
  localparam logic [DCAUSE_W-1:0] DCAUSE_DBGREQ = 3'd3;
  localparam logic [DCAUSE_W-1:0] DCAUSE_HALT   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MTVAL,
    S_W_MSTATUS,
    S_W_MEPC,
    S_W_DCSR,
    S_ASSERT
  } state_e;

  state_e            state_q, state_d;
  logic              dm_q, dm_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic [XLEN-1:0]   mtval_q, mtval_d;

  logic              csr_we_c;
  logic [XLEN-1:0]   csr_waddr_c;
  logic [XLEN-1:0]   csr_wdata_c;

  logic              exc_ecall, exc_ebreak, exc_any;
  logic [XLEN-1:0]   exc_cause, exc_mtval;
  logic              dbg_ebreak, dbg_halt, dbg_req, dbg_step, dbg_enter;
  logic [DCAUSE_W-1:0] dbg_cause;
  logic [XLEN-1:0]   dbg_pc;
  logic [NUM_IRQ-1:0] irq_masked;
  logic [IDX_W-1:0]  irq_idx;
  logic              irq_take, dret_take;
  logic [XLEN-1:0]   irq_cause, irq_target, trap_base;
  logic [XLEN-1:0]   mret_mstatus, trap_mstatus;
  logic              unused_c;

  assign unused_c = ^{csr.mie_i, csr.dcsr_i, csr.mtvec_i, csr.mstatus_i};

  // Exception decode, illegal > ecall > ebreak
  assign exc_ecall  = inst_ecall_i & inst_valid_i;
  assign exc_ebreak = inst_ebreak_i & inst_valid_i & ~csr.dcsr_i[15];
  assign exc_any    = illegal_inst_i | exc_ecall | exc_ebreak;

  always_comb begin : exc_dec
    exc_cause = '0;
    exc_mtval = '0;
    if (illegal_inst_i) begin
      exc_cause = XLEN'(2);
      exc_mtval = inst_i;
    end else if (exc_ecall) begin
      exc_cause = XLEN'(11);
    end else if (exc_ebreak) begin
      exc_cause = XLEN'(3);
      exc_mtval = inst_addr_i;
    end
  end

  // Debug entry only from normal mode
  assign dbg_ebreak = ~dm_q & inst_ebreak_i & inst_valid_i & csr.dcsr_i[15];
  assign dbg_halt   = ~dm_q & debug_req_i & inst_valid_i & (inst_addr_i == RESET_ADDR);
  assign dbg_req    = ~dm_q & debug_req_i & inst_valid_i;
  assign dbg_step   = ~dm_q & csr.dcsr_i[2] & inst_valid_i & inst_executed_i;
  assign dbg_enter  = dbg_halt | dbg_req | dbg_step;
  assign dbg_cause  = dbg_halt ? DCAUSE_HALT : (dbg_req ? DCAUSE_DBGREQ : DCAUSE_STEP);
  assign dbg_pc     = dbg_halt ? RESET_ADDR : inst_addr_i;

  // Fixed-priority interrupt pick, lowest line index wins
  assign irq_masked = irq_i & csr.mie_i[IRQ_BASE +: NUM_IRQ];
  assign irq_take   = inst_valid_i & csr.mstatus_i[3] & ~dm_q & (|irq_masked);

  always_comb begin : irq_pick
    irq_idx = '0;
    for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
      if (irq_masked[k]) irq_idx = IDX_W'(k);
    end
  end

  assign irq_cause = 32'h8000_0000 | (XLEN'(IRQ_BASE) + XLEN'(irq_idx));
  assign trap_base = {csr.mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign irq_target = (csr.mtvec_i[1:0] == 2'b01)
                    ? trap_base + ((XLEN'(IRQ_BASE) + XLEN'(irq_idx)) << 2)
                    : trap_base;
`else
  assign irq_target = trap_base;
`endif

  assign dret_take = inst_dret_i & dm_q;

  // mstatus images: MIE bit 3, MPIE bit 7, MPP bits 12:11
  assign mret_mstatus = {csr.mstatus_i[31:13], 2'b11, csr.mstatus_i[10:8], 1'b1,
                         csr.mstatus_i[6:4], csr.mstatus_i[7], csr.mstatus_i[2:0]};
  assign trap_mstatus = {csr.mstatus_i[31:13], 2'b11, csr.mstatus_i[10:8], csr.mstatus_i[3],
                         csr.mstatus_i[6:4], 1'b0, csr.mstatus_i[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dm_q     <= 1'b0;
      cause_q  <= '0;
      epc_q    <= '0;
      target_q <= '0;
      mtval_q  <= '0;
    end else begin
      state_q  <= state_d;
      dm_q     <= dm_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      target_q <= target_d;
      mtval_q  <= mtval_d;
    end
  end

  // Arbitration in IDLE, then one CSR write per busy state; busy states ignore inputs
  always_comb begin : fsm_comb
    state_d      = state_q;
    dm_d         = dm_q;
    cause_d      = cause_q;
    epc_d        = epc_q;
    target_d     = target_q;
    mtval_d      = mtval_q;
    csr_we_c     = 1'b0;
    csr_waddr_c  = '0;
    csr_wdata_c  = '0;
    stall_flag_o = 1'b0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    irq_ack_o    = '0;

    unique case (state_q)
      S_IDLE: begin
        // rst_n gate keeps every output quiet while reset is held
        if (rst_n) begin
          if (exc_any) begin
            stall_flag_o = 1'b1;
            if (dm_q) begin
              target_d = debug_halt_addr_i;
              state_d  = S_ASSERT;
            end else begin
              cause_d     = exc_cause;
              mtval_d     = exc_mtval;
              epc_d       = inst_addr_i;
              target_d    = trap_base;
              csr_we_c    = 1'b1;
              csr_waddr_c = XLEN'(CSR_MCAUSE);
              csr_wdata_c = exc_cause;
              state_d     = S_W_MTVAL;
            end
          end else if (dbg_ebreak) begin
            stall_flag_o = 1'b1;
            dm_d         = 1'b1;
            target_d     = debug_halt_addr_i;
            state_d      = S_ASSERT;
          end else if (dbg_enter) begin
            stall_flag_o = 1'b1;
            dm_d         = 1'b1;
            cause_d      = XLEN'(dbg_cause);
            epc_d        = dbg_pc;
            target_d     = debug_halt_addr_i;
            csr_we_c     = 1'b1;
            csr_waddr_c  = XLEN'(CSR_DPC);
            csr_wdata_c  = dbg_pc;
            state_d      = S_W_DCSR;
          end else if (irq_take) begin
            stall_flag_o = 1'b1;
            cause_d      = irq_cause;
            mtval_d      = '0;
            epc_d        = inst_addr_i;
            target_d     = irq_target;
            irq_ack_o    = NUM_IRQ'(1) << irq_idx;
            csr_we_c     = 1'b1;
            csr_waddr_c  = XLEN'(CSR_MCAUSE);
            csr_wdata_c  = irq_cause;
            state_d      = S_W_MTVAL;
          end else if (inst_mret_i) begin
            stall_flag_o = 1'b1;
            target_d     = csr.mepc_i;
            csr_we_c     = 1'b1;
            csr_waddr_c  = XLEN'(CSR_MSTATUS);
            csr_wdata_c  = mret_mstatus;
            state_d      = S_ASSERT;
          end else if (dret_take) begin
            stall_flag_o = 1'b1;
            dm_d         = 1'b0;
            target_d     = csr.dpc_i;
            state_d      = S_ASSERT;
          end
        end
      end
      S_W_MTVAL: begin
        stall_flag_o = 1'b1;
        csr_we_c     = 1'b1;
        csr_waddr_c  = XLEN'(CSR_MTVAL);
        csr_wdata_c  = mtval_q;
        state_d      = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        stall_flag_o = 1'b1;
        csr_we_c     = 1'b1;
        csr_waddr_c  = XLEN'(CSR_MSTATUS);
        csr_wdata_c  = trap_mstatus;
        state_d      = S_W_MEPC;
      end
      S_W_MEPC: begin
        stall_flag_o = 1'b1;
        csr_we_c     = 1'b1;
        csr_waddr_c  = XLEN'(CSR_MEPC);
        csr_wdata_c  = epc_q;
        state_d      = S_ASSERT;
      end
      S_W_DCSR: begin
        stall_flag_o = 1'b1;
        csr_we_c     = 1'b1;
        csr_waddr_c  = XLEN'(CSR_DCSR);
        csr_wdata_c  = {csr.dcsr_i[31:9], cause_q[DCAUSE_W-1:0], csr.dcsr_i[5:0]};
        state_d      = S_ASSERT;
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = target_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign csr.csr_we_o    = csr_we_c;
  assign csr.csr_waddr_o = csr_waddr_c;
  assign csr.csr_wdata_o = csr_wdata_c;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: vector table for single-request outcomes plus hand sequences
// for the full trap write order, debug halt/dret round trip and reset mid-sequence.
module tb_trap_ctrl;
  localparam logic [31:0] HALT_ADDR = 32'h0000_0800;
`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] VEC_TGT = 32'h0000_024C;
`else
  localparam logic [31:0] VEC_TGT = 32'h0000_0200;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid, inst_executed, illegal_inst;
  logic        inst_ecall, inst_ebreak, inst_mret, inst_dret, debug_req;
  logic [31:0] inst_addr, inst, debug_halt_addr, int_addr;
  logic [15:0] irq, irq_ack;
  logic        stall_flag, int_assert;

  trap_ctrl_if bus ();

  trap_ctrl #(.NUM_IRQ(16), .RESET_ADDR(32'h0)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .inst_valid_i      (inst_valid),
    .inst_executed_i   (inst_executed),
    .inst_addr_i       (inst_addr),
    .inst_i            (inst),
    .illegal_inst_i    (illegal_inst),
    .inst_ecall_i      (inst_ecall),
    .inst_ebreak_i     (inst_ebreak),
    .inst_mret_i       (inst_mret),
    .inst_dret_i       (inst_dret),
    .csr               (bus),
    .irq_i             (irq),
    .debug_req_i       (debug_req),
    .debug_halt_addr_i (debug_halt_addr),
    .stall_flag_o      (stall_flag),
    .int_assert_o      (int_assert),
    .int_addr_o        (int_addr),
    .irq_ack_o         (irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, exec, ill, ecall, ebreak, mret, dret, dreq;
    logic [31:0] pc, inst, mstatus, mie, mtvec, mepc, dpc, dcsr;
    logic [15:0] irq;
    logic        e_we;
    logic [31:0] e_waddr, e_wdata;
    logic        e_stall;
    logic [15:0] e_ack;
    int          e_lat;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vq[$];
  vec_t v;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got 0x%08h, want 0x%08h", what, idx, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t r;
    r = '{default: '0};
    r.mtvec = 32'h200;
    return r;
  endfunction

  function automatic vec_t expect_v(input vec_t r, input logic we, input logic [31:0] wa,
                                    input logic [31:0] wd, input logic st, input logic [15:0] ack,
                                    input int lat, input logic [31:0] tgt);
    vec_t o;
    o = r;
    o.e_we = we; o.e_waddr = wa; o.e_wdata = wd; o.e_stall = st;
    o.e_ack = ack; o.e_lat = lat; o.e_tgt = tgt;
    return o;
  endfunction

  task automatic drive(input vec_t r);
    inst_valid = r.valid; inst_executed = r.exec; illegal_inst = r.ill;
    inst_ecall = r.ecall; inst_ebreak = r.ebreak; inst_mret = r.mret;
    inst_dret = r.dret; debug_req = r.dreq; inst_addr = r.pc; inst = r.inst; irq = r.irq;
    bus.mstatus_i = r.mstatus; bus.mie_i = r.mie; bus.mtvec_i = r.mtvec;
    bus.mepc_i = r.mepc; bus.dpc_i = r.dpc; bus.dcsr_i = r.dcsr;
  endtask

  task automatic drive_idle();
    inst_valid = 1'b0; inst_executed = 1'b0; illegal_inst = 1'b0; inst_ecall = 1'b0;
    inst_ebreak = 1'b0; inst_mret = 1'b0; inst_dret = 1'b0; debug_req = 1'b0; irq = '0;
  endtask

  // Request cycle outputs, then redirect latency/target with inputs quiet
  task automatic run_vec(input int idx, input vec_t r);
    int          lat;
    logic [31:0] tgt;
    @(negedge clk); drive(r); #1;
    chk("csr_we", idx, 32'(bus.csr_we_o), 32'(r.e_we));
    if (r.e_we) begin
      chk("csr_waddr", idx, bus.csr_waddr_o, r.e_waddr);
      chk("csr_wdata", idx, bus.csr_wdata_o, r.e_wdata);
    end
    chk("stall", idx, 32'(stall_flag), 32'(r.e_stall));
    chk("irq_ack", idx, 32'(irq_ack), 32'(r.e_ack));
    lat = 0; tgt = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk); drive_idle(); #1;
      if (int_assert && lat == 0) begin lat = n; tgt = int_addr; end
    end
    chk("redirect_latency", idx, 32'(lat), 32'(r.e_lat));
    if (r.e_lat != 0) chk("redirect_addr", idx, tgt, r.e_tgt);
  endtask

  task automatic cyc(input string tag, input logic we, input logic [31:0] wa, input logic [31:0] wd,
                     input logic st, input logic ia, input logic [31:0] ia_addr);
    chk({tag, "_we"}, 0, 32'(bus.csr_we_o), 32'(we));
    if (we) begin
      chk({tag, "_waddr"}, 0, bus.csr_waddr_o, wa);
      chk({tag, "_wdata"}, 0, bus.csr_wdata_o, wd);
    end
    chk({tag, "_stall"}, 0, 32'(stall_flag), 32'(st));
    chk({tag, "_int_assert"}, 0, 32'(int_assert), 32'(ia));
    if (ia) chk({tag, "_int_addr"}, 0, int_addr, ia_addr);
  endtask

  initial begin
    int quiet;
    debug_halt_addr = HALT_ADDR;
    rst_n = 1'b0;
    drive(blank());

    // Vector table: normal mode, then debug-mode vectors in entry/exit order
    v = blank(); v.valid = 1;
    vq.push_back(expect_v(v, 0, 0, 0, 0, 16'h0, 0, 0));
    v = blank(); v.valid = 1; v.pc = 32'h100; v.irq = 16'h0008; v.mie = 32'h0008_0000; v.mstatus = 32'h8;
    vq.push_back(expect_v(v, 1, 32'h342, 32'h8000_0013, 1, 16'h0008, 4, 32'h200));
    v = blank(); v.valid = 1; v.irq = 16'h0006; v.mie = 32'hFFFF_0000; v.mstatus = 32'h8;
    vq.push_back(expect_v(v, 1, 32'h342, 32'h8000_0011, 1, 16'h0002, 4, 32'h200));
    v = blank(); v.valid = 1; v.pc = 32'h100; v.irq = 16'h0008; v.mie = 32'h0008_0000; v.mstatus = 32'h8; v.mtvec = 32'h201;
    vq.push_back(expect_v(v, 1, 32'h342, 32'h8000_0013, 1, 16'h0008, 4, VEC_TGT));
    v = blank(); v.valid = 1; v.ill = 1; v.pc = 32'h40; v.inst = 32'hFFFF_FFFF; v.irq = 16'h0008;
    v.mie = 32'h0008_0000; v.mstatus = 32'h8; v.mtvec = 32'h201;
    vq.push_back(expect_v(v, 1, 32'h342, 32'h2, 1, 16'h0, 4, 32'h200));
    v = blank(); v.valid = 1; v.ecall = 1; v.mtvec = 32'h300;
    vq.push_back(expect_v(v, 1, 32'h342, 32'hB, 1, 16'h0, 4, 32'h300));
    v = blank(); v.valid = 1; v.ebreak = 1; v.pc = 32'h20;
    vq.push_back(expect_v(v, 1, 32'h342, 32'h3, 1, 16'h0, 4, 32'h200));
    v = blank(); v.valid = 1; v.irq = 16'h0008; v.mie = 32'h0010_0000; v.mstatus = 32'h8;
    vq.push_back(expect_v(v, 0, 0, 0, 0, 16'h0, 0, 0));
    v = blank(); v.valid = 1; v.irq = 16'h0008; v.mie = 32'h0008_0000;
    vq.push_back(expect_v(v, 0, 0, 0, 0, 16'h0, 0, 0));
    v = blank(); v.irq = 16'h0008; v.mie = 32'h0008_0000; v.mstatus = 32'h8;
    vq.push_back(expect_v(v, 0, 0, 0, 0, 16'h0, 0, 0));
    v = blank(); v.mret = 1; v.mstatus = 32'h80; v.mepc = 32'h104;
    vq.push_back(expect_v(v, 1, 32'h300, 32'h1888, 1, 16'h0, 1, 32'h104));
    v = blank(); v.dret = 1; v.dpc = 32'h8;
    vq.push_back(expect_v(v, 0, 0, 0, 0, 16'h0, 0, 0));
    v = blank(); v.valid = 1; v.dreq = 1; v.pc = 32'h0;
    vq.push_back(expect_v(v, 1, 32'h7B1, 32'h0, 1, 16'h0, 2, HALT_ADDR));
    v = blank(); v.valid = 1; v.irq = 16'h0008; v.mie = 32'h0008_0000; v.mstatus = 32'h8;
    vq.push_back(expect_v(v, 0, 0, 0, 0, 16'h0, 0, 0));
    v = blank(); v.valid = 1; v.ecall = 1;
    vq.push_back(expect_v(v, 0, 0, 0, 1, 16'h0, 1, HALT_ADDR));
    v = blank(); v.dret = 1; v.dpc = 32'h8;
    vq.push_back(expect_v(v, 0, 0, 0, 1, 16'h0, 1, 32'h8));
    v = blank(); v.valid = 1; v.dreq = 1; v.pc = 32'h200;
    vq.push_back(expect_v(v, 1, 32'h7B1, 32'h200, 1, 16'h0, 2, HALT_ADDR));
    v = blank(); v.valid = 1; v.dreq = 1; v.pc = 32'h300;
    vq.push_back(expect_v(v, 0, 0, 0, 0, 16'h0, 0, 0));
    v = blank(); v.dret = 1; v.dpc = 32'h204;
    vq.push_back(expect_v(v, 0, 0, 0, 1, 16'h0, 1, 32'h204));
    v = blank(); v.valid = 1; v.exec = 1; v.dcsr = 32'h4; v.pc = 32'h60;
    vq.push_back(expect_v(v, 1, 32'h7B1, 32'h60, 1, 16'h0, 2, HALT_ADDR));
    v = blank(); v.dret = 1; v.dpc = 32'h64;
    vq.push_back(expect_v(v, 0, 0, 0, 1, 16'h0, 1, 32'h64));
    v = blank(); v.valid = 1; v.ebreak = 1; v.dcsr = 32'h8000;
    vq.push_back(expect_v(v, 0, 0, 0, 1, 16'h0, 1, HALT_ADDR));
    v = blank(); v.dret = 1; v.dpc = 32'h10;
    vq.push_back(expect_v(v, 0, 0, 0, 1, 16'h0, 1, 32'h10));
    v = blank(); v.valid = 1; v.ecall = 1; v.dreq = 1; v.mret = 1; v.pc = 32'h80;
    v.irq = 16'h0008; v.mie = 32'h0008_0000; v.mstatus = 32'h8;
    vq.push_back(expect_v(v, 1, 32'h342, 32'hB, 1, 16'h0, 4, 32'h200));
    v = blank(); v.valid = 1; v.dreq = 1; v.pc = 32'h44; v.irq = 16'h0008; v.mie = 32'h0008_0000; v.mstatus = 32'h8;
    vq.push_back(expect_v(v, 1, 32'h7B1, 32'h44, 1, 16'h0, 2, HALT_ADDR));
    v = blank(); v.dret = 1; v.dpc = 32'h48;
    vq.push_back(expect_v(v, 0, 0, 0, 1, 16'h0, 1, 32'h48));
    v = blank(); v.valid = 1; v.mret = 1; v.mepc = 32'h104; v.irq = 16'h0008; v.mie = 32'h0008_0000; v.mstatus = 32'h88;
    vq.push_back(expect_v(v, 1, 32'h342, 32'h8000_0013, 1, 16'h0008, 4, 32'h200));

    // Reset state
    #12;
    chk("rst_csr_we", 0, 32'(bus.csr_we_o), 32'h0);
    chk("rst_csr_waddr", 0, bus.csr_waddr_o, 32'h0);
    chk("rst_csr_wdata", 0, bus.csr_wdata_o, 32'h0);
    chk("rst_stall", 0, 32'(stall_flag), 32'h0);
    chk("rst_int_assert", 0, 32'(int_assert), 32'h0);
    chk("rst_int_addr", 0, int_addr, 32'h0);
    chk("rst_irq_ack", 0, 32'(irq_ack), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vq[i]) run_vec(i, vq[i]);

    // Full interrupt trap: per-cycle write order, busy states ignore new requests
    @(negedge clk);
    v = blank(); v.valid = 1; v.pc = 32'h100; v.irq = 16'h0008; v.mie = 32'h0008_0000; v.mstatus = 32'h8;
    drive(v); #1;
    cyc("trap_c0", 1, 32'h342, 32'h8000_0013, 1, 0, 0);
    chk("trap_c0_ack", 0, 32'(irq_ack), 32'h8);
    @(negedge clk); irq = 16'h0001; illegal_inst = 1'b1; bus.mie_i = 32'hFFFF_0000; #1;
    cyc("trap_c1", 1, 32'h343, 32'h0, 1, 0, 0);
    chk("trap_c1_ack", 0, 32'(irq_ack), 32'h0);
    @(negedge clk); #1;
    cyc("trap_c2", 1, 32'h300, 32'h1880, 1, 0, 0);
    @(negedge clk); #1;
    cyc("trap_c3", 1, 32'h341, 32'h100, 1, 0, 0);
    @(negedge clk); drive_idle(); #1;
    cyc("trap_c4", 0, 0, 0, 0, 1, 32'h200);
    @(negedge clk); #1;
    cyc("trap_c5", 0, 0, 0, 0, 0, 0);

    // Debug halt at reset PC, dcsr cause field, then dret and a normal-mode irq
    @(negedge clk);
    v = blank(); v.valid = 1; v.dreq = 1; v.pc = 32'h0; v.dcsr = 32'h4000_0003;
    drive(v); #1;
    cyc("halt_c0", 1, 32'h7B1, 32'h0, 1, 0, 0);
    @(negedge clk); drive_idle(); #1;
    cyc("halt_c1", 1, 32'h7B0, 32'h4000_0143, 1, 0, 0);
    @(negedge clk); #1;
    cyc("halt_c2", 0, 0, 0, 0, 1, HALT_ADDR);
    @(negedge clk);
    v = blank(); v.dret = 1; v.dpc = 32'h8;
    drive(v); #1;
    cyc("dret_c0", 0, 0, 0, 1, 0, 0);
    @(negedge clk); drive_idle(); #1;
    cyc("dret_c1", 0, 0, 0, 0, 1, 32'h8);
    @(negedge clk);
    v = blank(); v.valid = 1; v.irq = 16'h0008; v.mie = 32'h0008_0000; v.mstatus = 32'h8;
    drive(v); #1;
    chk("post_dret_irq_ack", 0, 32'(irq_ack), 32'h8);
    for (int n = 0; n < 6; n++) begin @(negedge clk); drive_idle(); end

    // Reset asserted in W_MSTATUS aborts the sequence
    @(negedge clk);
    v = blank(); v.valid = 1; v.pc = 32'h100; v.irq = 16'h0008; v.mie = 32'h0008_0000; v.mstatus = 32'h8;
    drive(v); #1;
    @(negedge clk); drive_idle(); #1;
    @(negedge clk); #1;
    cyc("abort_pre", 1, 32'h300, 32'h1880, 1, 0, 0);
    rst_n = 1'b0; #1;
    cyc("abort_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    quiet = 0;
    for (int n = 0; n < 6; n++) begin
      #1; if (int_assert || bus.csr_we_o || stall_flag) quiet++;
      @(negedge clk);
    end
    chk("abort_quiet_cycles", 0, 32'(quiet), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
endmodule
